spike_rate_encoder: RTL and testbench
=====================================

# spike_rate_encoder

Converts a per-synapse intensity vector into binary spike trains over a fixed number of timesteps, using a first-order sigma-delta accumulator per channel. It is the producer side of the LIF neuron's input interface. Its `spikes` bus drives the neuron's `inputs`, and `spikes_valid` drives the neuron's `enable`, so the neuron integrates exactly one timestep per valid pulse. Intensities are loaded one channel at a time through a valid/ready port; a run is then launched with `start`.

## Interface

**Parameters**
- `SYNAPSES`, default 32: number of output spike channels; must equal the neuron's `SYNAPSES`.
- `VALUE_BITS`, default 4: intensity width. The spike rate of a channel is value / 2^VALUE_BITS.
- `STEPS_BITS`, default 4: width of the timestep count.
- `INDEX_BITS`, default $clog2(SYNAPSES): width of the channel index.

**Ports**
- `clk`, in, 1: single clock; all state changes on its rising edge.
- `rst_n`, in, 1: reset. Asynchronous, active-low.
- `load_valid`, in, 1: a load word is present.
- `load_ready`, out, 1: the block accepts loads; high only in IDLE.
- `load_index`, in, INDEX_BITS: channel to write.
- `load_value`, in, VALUE_BITS: intensity for that channel.
- `start`, in, 1: launch a run; sampled only in IDLE.
- `num_steps`, in, STEPS_BITS: timesteps for the run; captured when `start` is accepted.
- `step_en`, in, 1: advance one timestep in RUN; used as a throttle/stall.
- `busy`, out, 1: high while in RUN.
- `spikes`, out, SYNAPSES: registered spike vector of the most recent timestep.
- `spikes_valid`, out, 1: one-cycle pulse per timestep; `spikes` is new in that cycle.
- `step_count`, out, STEPS_BITS: timesteps completed in the current or last run.
- `done`, out, 1: one-cycle pulse marking the end of a run.

## Operation

**Storage**
- `value[SYNAPSES]`: VALUE_BITS each.
- `acc[SYNAPSES]`: VALUE_BITS each.
- Remaining step counter, plus the state register.

**State machine**
- Two states: IDLE and RUN.
- Reset state is IDLE.

**Load**
- A load is accepted when `load_valid` and `load_ready` are both high.
- On acceptance, `value[load_index]` is written with `load_value`.
- A `load_index` ≥ SYNAPSES is accepted but does not write anything.
- In RUN, `load_ready` is 0 and `load_valid` is ignored.

**Start**
- `start` is accepted in IDLE only. It captures `num_steps`, clears every `acc` to 0, clears `step_count`, and clears `spikes`.
- If `num_steps` is 0: state stays IDLE and `done` pulses on the following cycle. `spikes_valid` never asserts.
- Otherwise the state goes to RUN.
- `start` in RUN is ignored.
- When a load and `start` occur in the same cycle, both take effect. The run uses the newly written value.

**Step (RUN with `step_en`=1)**
- Per channel: `{c, s} = acc[i] + value[i]`, computed at VALUE_BITS+1 bits.
- `acc[i]` takes `s`; `spikes[i]` takes `c`.
- `step_count` increments.
- `spikes_valid` is high during the next cycle.
- In RUN with `step_en`=0, nothing changes and `spikes_valid` is 0 on the next cycle.

**Last step**
- On the step that brings `step_count` to the captured `num_steps`, the state returns to IDLE at the same edge.
- `done` pulses in the same cycle as the final `spikes_valid`.

**Rates over N steps, starting from acc=0**
- Channel i emits floor(N·value[i] / 2^VALUE_BITS) spikes.
- Value 0 never spikes.
- The carry-out wraps the accumulator modulo 2^VALUE_BITS; no saturation is applied.

**Hold behaviour**
- `spikes` holds its last value between pulses and after the run ends.
- `value[]` persists across runs until it is overwritten or reset.

## Timing

**Reset values** (while `rst_n` is 0, applied asynchronously)
- `load_ready` = 1 (state IDLE); `busy` = 0; `spikes` = 0; `spikes_valid` = 0; `step_count` = 0; `done` = 0.
- All `value[]` and `acc[]` are cleared to 0.

**Latencies**
- `start` accepted at edge T → `busy` high from T+1.
- With `step_en` held at 1, the k-th `spikes_valid` occurs in cycle T+k+1.
- A run of N steps with continuous `step_en` keeps `busy` high for exactly N cycles.
- `load_ready` returns to 1 in the cycle where `done` is high.
- Load write → the value is usable by a `start` accepted at the same edge.

**Reset mid-run**
- Reset aborts the run immediately.
- After `rst_n` rises, the block sits in IDLE with all intensities zero.

## Test plan

- **Rates:** load ch0=8, ch1=15, ch2=0, ch3=1 (others 0); start with `num_steps`=15 and `step_en`=1. Required: 15 consecutive `spikes_valid`; spike counts 7, 14, 0, 0; ch0 spikes on steps 2, 4, …, 14; `done` coincides with the 15th pulse; `busy` is high for 15 cycles.
- **Throttle:** same loads, `step_en` toggling 1,0,1,0… Required: pulses only after enabled cycles; identical spike sequence to the rates test; `busy` high for about 30 cycles.
- **Zero-length run:** start with `num_steps`=0. Required: `done` pulses exactly one cycle later; `spikes_valid` never asserts; `busy` stays 0.
- **Protocol during RUN:** start `num_steps`=5 with ch0=8; drive `load_valid` with ch0=15 plus a second `start` during RUN. Required: `load_ready`=0; ch0 stays 8, so exactly 2 spikes on ch0; the extra `start` has no effect.
- **Reset mid-run:** assert `rst_n`=0 at step 3 of a 10-step run with ch0=15. Required: all outputs go to their reset values immediately; after release, a 4-step run without reloading gives `spikes`=0 on every pulse.
- **Simultaneous load and start:** in IDLE, load ch0=15 and start `num_steps`=2 in the same cycle. Required: ch0 is 0 on step 1 and 1 on step 2 (acc 15 → 14); `done` pulses with the second `spikes_valid`.

Source files
------------

// File: rtl/spike_rate_encoder.sv
// Per-channel sigma-delta rate encoder: turns a loaded intensity vector into
// binary spike trains, one spike vector per enabled timestep of a run.
module spike_rate_encoder #(
   parameter int SYNAPSES   = 32,
   parameter int VALUE_BITS = 4,
   parameter int STEPS_BITS = 4,
   parameter int INDEX_BITS = (SYNAPSES > 1) ? $clog2(SYNAPSES) : 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  load_valid,
   output logic                  load_ready,
   input  logic [INDEX_BITS-1:0] load_index,
   input  logic [VALUE_BITS-1:0] load_value,
   input  logic                  start,
   input  logic [STEPS_BITS-1:0] num_steps,
   input  logic                  step_en,
   output logic                  busy,
   output logic [SYNAPSES-1:0]   spikes,
   output logic                  spikes_valid,
   output logic [STEPS_BITS-1:0] step_count,
   output logic                  done
);

   // Load port handshake: a word transfers on a rising edge where load_valid
   // and load_ready are both high; load_ready is high exactly while IDLE.

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   state_e state_q;
   state_e state_d;

   logic [SYNAPSES-1:0][VALUE_BITS-1:0] value_q;
   logic [SYNAPSES-1:0][VALUE_BITS-1:0] value_d;
   logic [SYNAPSES-1:0][VALUE_BITS-1:0] acc_q;
   logic [SYNAPSES-1:0][VALUE_BITS-1:0] acc_d;
   logic [SYNAPSES-1:0][VALUE_BITS:0]   step_sum;
   logic [SYNAPSES-1:0]                 spikes_q;
   logic [SYNAPSES-1:0]                 spikes_d;
   logic                                spikes_valid_q;
   logic                                spikes_valid_d;
   logic [STEPS_BITS-1:0]               step_count_q;
   logic [STEPS_BITS-1:0]               step_count_d;
   logic [STEPS_BITS-1:0]               remaining_q;
   logic [STEPS_BITS-1:0]               remaining_d;
   logic                                done_q;
   logic                                done_d;

   logic load_fire;
   logic start_fire;
   logic step_fire;
   logic last_step;
   logic zero_run;

   assign load_fire  = load_valid && load_ready;
   assign start_fire = (state_q == ST_IDLE) && start;
   assign zero_run   = (num_steps == '0);
   assign step_fire  = (state_q == ST_RUN) && step_en;
   assign last_step  = step_fire && (remaining_q == STEPS_BITS'(1));

   // Carry out of the widened sum is the spike; the low bits wrap into acc.
   for (genvar g = 0; g < SYNAPSES; g++) begin : g_sum
      assign step_sum[g] = {1'b0, acc_q[g]} + {1'b0, value_q[g]};
   end

   // FSM: state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM: next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (start_fire && !zero_run) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (last_step) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // FSM: outputs
   always_comb begin
      load_ready = 1'b0;
      busy       = 1'b0;
      case (state_q)
         ST_IDLE: load_ready = 1'b1;
         ST_RUN:  busy       = 1'b1;
         default: load_ready = 1'b0;
      endcase
   end

   // Intensity store; indices past the last channel match no entry.
   always_comb begin
      value_d = value_q;
      for (int i = 0; i < SYNAPSES; i++) begin
         if (load_fire && (int'(load_index) == i)) begin
            value_d[i] = load_value;
         end
      end
   end

   always_comb begin
      acc_d          = acc_q;
      spikes_d       = spikes_q;
      spikes_valid_d = 1'b0;
      step_count_d   = step_count_q;
      remaining_d    = remaining_q;
      done_d         = 1'b0;

      if (start_fire) begin
         acc_d        = '0;
         spikes_d     = '0;
         step_count_d = '0;
         remaining_d  = num_steps;
         done_d       = zero_run;
      end

      if (step_fire) begin
         for (int i = 0; i < SYNAPSES; i++) begin
            acc_d[i]    = step_sum[i][VALUE_BITS-1:0];
            spikes_d[i] = step_sum[i][VALUE_BITS];
         end
         spikes_valid_d = 1'b1;
         step_count_d   = step_count_q + STEPS_BITS'(1);
         remaining_d    = remaining_q - STEPS_BITS'(1);
         done_d         = last_step;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         value_q        <= '0;
         acc_q          <= '0;
         spikes_q       <= '0;
         spikes_valid_q <= 1'b0;
         step_count_q   <= '0;
         remaining_q    <= '0;
         done_q         <= 1'b0;
      end else begin
         value_q        <= value_d;
         acc_q          <= acc_d;
         spikes_q       <= spikes_d;
         spikes_valid_q <= spikes_valid_d;
         step_count_q   <= step_count_d;
         remaining_q    <= remaining_d;
         done_q         <= done_d;
      end
   end

   assign spikes       = spikes_q;
   assign spikes_valid = spikes_valid_q;
   assign step_count   = step_count_q;
   assign done         = done_q;

endmodule

// File: tb/tb_spike_rate_encoder.sv
// Bench for spike_rate_encoder: directed runs plus randomized runs checked
// against cumulative-rate arithmetic, floor(k*v/2^VALUE_BITS) spikes by step k.
module tb_spike_rate_encoder;

   localparam int S  = 20;
   localparam int VB = 4;
   localparam int SB = 4;
   localparam int IB = 5;

   logic          clk;
   logic          rst_n;
   logic          load_valid;
   logic          load_ready;
   logic [IB-1:0] load_index;
   logic [VB-1:0] load_value;
   logic          start;
   logic [SB-1:0] num_steps;
   logic          step_en;
   logic          busy;
   logic [S-1:0]  spikes;
   logic          spikes_valid;
   logic [SB-1:0] step_count;
   logic          done;

   int vectors     = 0;
   int miscompares = 0;
   int model_val[S];
   int tot[S];
   int last_busy_cycles;
   logic [S-1:0] exp_q[$];

   spike_rate_encoder #(
      .SYNAPSES  (S),
      .VALUE_BITS(VB),
      .STEPS_BITS(SB),
      .INDEX_BITS(IB)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .load_valid  (load_valid),
      .load_ready  (load_ready),
      .load_index  (load_index),
      .load_value  (load_value),
      .start       (start),
      .num_steps   (num_steps),
      .step_en     (step_en),
      .busy        (busy),
      .spikes      (spikes),
      .spikes_valid(spikes_valid),
      .step_count  (step_count),
      .done        (done)
   );

   // Clock and watchdog
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Spikes expected at step k: change in cumulative count floor(k*v/16).
   function automatic logic [S-1:0] model_step(input int k);
      logic [S-1:0] v;
      for (int i = 0; i < S; i++) begin
         v[i] = (((k * model_val[i]) >> VB) != (((k - 1) * model_val[i]) >> VB));
      end
      return v;
   endfunction

   task automatic load_ch(input int idx, input int val);
      load_valid = 1'b1;
      load_index = IB'(idx);
      load_value = VB'(val);
      check("load_ready_idle", load_ready, 1);
      tick();
      load_valid = 1'b0;
      if (idx < S) model_val[idx] = val;
   endtask

   // mode 0: step_en held high; 1: toggling 1,0,...; 2: random
   task automatic run_steps(input int n, input int mode, input bit disturb,
                            input bit sim_load, input int sim_val);
      int k;
      int cyc;
      int bc;
      logic en;
      logic [S-1:0] exp_v;
      logic [S-1:0] last_v;
      if (sim_load) begin
         load_valid = 1'b1;
         load_index = '0;
         load_value = VB'(sim_val);
         model_val[0] = sim_val;
      end
      exp_q.delete();
      for (int s = 1; s <= n; s++) exp_q.push_back(model_step(s));
      for (int i = 0; i < S; i++) tot[i] = 0;
      start     = 1'b1;
      num_steps = SB'(n);
      check("ready_at_start", load_ready, 1);
      tick();
      start      = 1'b0;
      num_steps  = '0;
      load_valid = 1'b0;
      check("busy_after_start", busy, (n != 0));
      check("spikes_cleared", spikes, 0);
      check("step_count_cleared", step_count, 0);
      check("valid_after_start", spikes_valid, 0);
      check("done_after_start", done, (n == 0));
      if (n == 0) begin
         tick();
         check("zero_done_once", done, 0);
         check("zero_busy", busy, 0);
         check("zero_valid", spikes_valid, 0);
         return;
      end
      k = 0;
      cyc = 0;
      bc = 0;
      last_v = '0;
      while (k < n && cyc < 200) begin
         case (mode)
            0:       en = 1'b1;
            1:       en = (cyc % 2 == 0);
            default: en = 1'($urandom_range(0, 1));
         endcase
         step_en = en;
         if (disturb) begin
            load_valid = 1'b1;
            load_index = '0;
            load_value = 4'd15;
            start      = 1'b1;
            num_steps  = 4'd3;
            check("load_ready_run", load_ready, 0);
         end
         if (busy === 1'b1) bc++;
         tick();
         cyc++;
         if (en) begin
            k++;
            exp_v = exp_q.pop_front();
            last_v = exp_v;
            check("valid_step", spikes_valid, 1);
            check("spikes_step", spikes, exp_v);
            check("step_count", step_count, k);
            check("done_step", done, (k == n));
            check("busy_step", busy, (k < n));
            check("ready_step", load_ready, (k == n));
            for (int i = 0; i < S; i++) tot[i] += int'(spikes[i]);
         end else begin
            check("valid_stall", spikes_valid, 0);
            check("done_stall", done, 0);
            check("busy_stall", busy, 1);
            check("spikes_hold", spikes, last_v);
            check("count_stall", step_count, k);
         end
      end
      step_en    = 1'b0;
      load_valid = 1'b0;
      start      = 1'b0;
      num_steps  = '0;
      check("run_completed", k, n);
      last_busy_cycles = bc;
      if (mode == 0) check("busy_len", bc, n);
      if (mode == 1) check("busy_len_throttled", bc, 2 * n - 1);
      for (int i = 0; i < S; i++) check("spike_total", tot[i], (n * model_val[i]) >> VB);
      tick();
      check("post_valid", spikes_valid, 0);
      check("post_done", done, 0);
      check("post_busy", busy, 0);
      check("post_spikes_hold", spikes, last_v);
      check("post_count_hold", step_count, n);
   endtask

   initial begin
      rst_n      = 1'b1;
      load_valid = 1'b0;
      load_index = '0;
      load_value = '0;
      start      = 1'b0;
      num_steps  = '0;
      step_en    = 1'b0;
      for (int i = 0; i < S; i++) model_val[i] = 0;
      #2 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_load_ready", load_ready, 1);
      check("rst_busy", busy, 0);
      check("rst_spikes", spikes, 0);
      check("rst_valid", spikes_valid, 0);
      check("rst_step_count", step_count, 0);
      check("rst_done", done, 0);
      rst_n = 1'b1;
      tick();

      // rates
      load_ch(0, 8);
      load_ch(1, 15);
      load_ch(2, 0);
      load_ch(3, 1);
      run_steps(15, 0, 1'b0, 1'b0, 0);
      check("rates_ch0", tot[0], 7);
      check("rates_ch1", tot[1], 14);
      check("rates_ch2", tot[2], 0);
      check("rates_ch3", tot[3], 0);

      // throttle
      run_steps(15, 1, 1'b0, 1'b0, 0);
      check("throttle_ch1", tot[1], 14);

      // zero-length run
      run_steps(0, 0, 1'b0, 1'b0, 0);

      // protocol during run
      load_ch(1, 0);
      load_ch(3, 0);
      run_steps(5, 0, 1'b1, 1'b0, 0);
      check("protocol_ch0", tot[0], 2);

      // simultaneous load and start
      run_steps(2, 0, 1'b0, 1'b1, 15);
      check("simul_ch0", tot[0], 1);

      // reset mid-run
      start     = 1'b1;
      num_steps = 4'd10;
      tick();
      start     = 1'b0;
      step_en   = 1'b1;
      repeat (3) tick();
      check("mid_count", step_count, 3);
      check("mid_spikes", spikes, model_step(3));
      #2 rst_n = 1'b0;
      #1;
      check("arst_load_ready", load_ready, 1);
      check("arst_busy", busy, 0);
      check("arst_spikes", spikes, 0);
      check("arst_valid", spikes_valid, 0);
      check("arst_step_count", step_count, 0);
      check("arst_done", done, 0);
      step_en = 1'b0;
      for (int i = 0; i < S; i++) model_val[i] = 0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      tick();
      run_steps(4, 0, 1'b0, 1'b0, 0);
      check("after_reset_ch0", tot[0], 0);

      // randomized runs, including loads to nonexistent channels
      repeat (6) begin
         for (int i = 0; i < S; i++) load_ch(i, int'($urandom_range(0, 15)));
         load_ch(int'($urandom_range(S, 31)), 15);
         load_ch(int'($urandom_range(S, 31)), 7);
         run_steps(int'($urandom_range(1, 15)), 2, 1'b0, 1'b0, 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
